// File: rtl/pattern_match_accum_pkg.sv
// Shared types and the entry match rule for the mask-match accumulator.
package pattern_match_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        LOOP = 2'd2,
        END  = 2'd3
    } state_e;

    localparam logic MODE_SUBSET = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    // Callers zero-extend to this width; both match rules are unaffected by extra zero bits.
    localparam int MATCH_MAX_W = 64;

    function automatic logic match_f(
        input logic [MATCH_MAX_W-1:0] in_w,
        input logic [MATCH_MAX_W-1:0] mask,
        input logic                   mode
    );
        if (mode == MODE_EXACT) return (in_w == mask);
        return ((in_w & ~mask) == '0);
    endfunction

endpackage

// File: rtl/pattern_match_accum_if.sv
// Control, table-load and result signals of pattern_match_accum.
interface pattern_match_accum_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 4,
    parameter int DEPTH  = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic              START;
    logic              MODE;
    logic [DATA_W-1:0] I;
    logic              TBL_WE;
    logic [AW-1:0]     TBL_ADDR;
    logic [DATA_W-1:0] TBL_MASK;
    logic [OUT_W-1:0]  TBL_CODE;
    logic              BUSY;
    logic              DONE;
    logic [OUT_W-1:0]  O;
    logic [CW-1:0]     MATCH_CNT;

    modport master (
        output START, MODE, I, TBL_WE, TBL_ADDR, TBL_MASK, TBL_CODE,
        input  BUSY, DONE, O, MATCH_CNT
    );

    modport slave (
        input  START, MODE, I, TBL_WE, TBL_ADDR, TBL_MASK, TBL_CODE,
        output BUSY, DONE, O, MATCH_CNT
    );
endinterface

// File: rtl/pattern_match_accum_table.sv
// DEPTH-entry (mask, code) register file: synchronous-reset write port, combinational read port.
module pattern_table #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wmask,
    input  logic [OUT_W-1:0]  i_wcode,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rmask,
    output logic [OUT_W-1:0]  o_rcode
);
    logic [DEPTH-1:0][DATA_W-1:0] r_mask;
    logic [DEPTH-1:0][OUT_W-1:0]  r_code;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= '0;
            r_code <= '0;
        end else if (i_we) begin
            r_mask[i_waddr] <= i_wmask;
            r_code[i_waddr] <= i_wcode;
        end
    end

    assign o_rmask = r_mask[i_raddr];
    assign o_rcode = r_code[i_raddr];
endmodule

// File: rtl/pattern_match_accum.sv
// Scans the table one entry per cycle, ORing the codes of matching entries; publishes O/MATCH_CNT at scan end.
import pattern_match_pkg::*;

module pattern_match_accum #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 4,
    parameter int DEPTH  = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    pattern_match_accum_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_in;
    logic              r_mode;
    logic [OUT_W-1:0]  r_acc;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_mar;
    logic [OUT_W-1:0]  r_o;
    logic [CW-1:0]     r_match_cnt;
    logic              r_done;

    logic              w_we;
    logic              w_last;
    logic              w_hit;
    logic [DATA_W-1:0] w_mask;
    logic [OUT_W-1:0]  w_code;

    // Writes land only while idle so a running scan always sees a frozen table.
    assign w_we   = bus.TBL_WE && (r_state == IDLE) &&
                    ({1'b0, bus.TBL_ADDR} < (AW+1)'(DEPTH));
    assign w_last = (r_mar == AW'(DEPTH - 1));
    assign w_hit  = match_f(MATCH_MAX_W'(r_in), MATCH_MAX_W'(w_mask), r_mode);

    pattern_table #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_table (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_we    (w_we),
        .i_waddr (bus.TBL_ADDR),
        .i_wmask (bus.TBL_MASK),
        .i_wcode (bus.TBL_CODE),
        .i_raddr (r_mar),
        .o_rmask (w_mask),
        .o_rcode (w_code)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.START) w_state_nxt = INIT;
            INIT:    w_state_nxt = LOOP;
            LOOP:    if (w_last) w_state_nxt = END;
            END:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_in        <= '0;
            r_mode      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mar       <= '0;
            r_o         <= '0;
            r_match_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                INIT: begin
                    r_in   <= bus.I;
                    r_mode <= bus.MODE;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                    r_mar  <= '0;
                end
                LOOP: begin
                    if (w_hit) begin
                        r_acc <= r_acc | w_code;
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (!w_last) r_mar <= r_mar + AW'(1);
                end
                END: begin
                    r_o         <= r_acc;
                    r_match_cnt <= r_cnt;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY      = (r_state != IDLE);
    assign bus.DONE      = r_done;
    assign bus.O         = r_o;
    assign bus.MATCH_CNT = r_match_cnt;
endmodule

// File: tb/tb_pattern_match_accum.sv
// Randomized bench for pattern_match_accum against a table-walk reference model (8x8/4 and 4x4/2 builds).
module tb_pattern_match_accum;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_match_accum_if #(.DATA_W(8), .OUT_W(4), .DEPTH(8)) bus_a();
    pattern_match_accum_if #(.DATA_W(4), .OUT_W(2), .DEPTH(4)) bus_b();

    pattern_match_accum #(.DATA_W(8), .OUT_W(4), .DEPTH(8)) u_a (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus_a)
    );

    pattern_match_accum #(.DATA_W(4), .OUT_W(2), .DEPTH(4)) u_b (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus_b)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] ma [8];
    logic [3:0] ca [8];
    logic [3:0] mb [4];
    logic [1:0] cb [4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: walk every entry, apply the match rule, OR codes and count hits.
    task automatic model_a(input logic [7:0] i, input logic mode, output logic [3:0] o, output int cnt);
        bit hit;
        o = '0;
        cnt = 0;
        for (int e = 0; e < 8; e++) begin
            hit = mode ? (i == ma[e]) : ((i | ma[e]) == ma[e]);
            if (hit) begin
                o = o | ca[e];
                cnt++;
            end
        end
    endtask

    task automatic model_b(input logic [3:0] i, input logic mode, output logic [1:0] o, output int cnt);
        bit hit;
        o = '0;
        cnt = 0;
        for (int e = 0; e < 4; e++) begin
            hit = mode ? (i == mb[e]) : ((i | mb[e]) == mb[e]);
            if (hit) begin
                o = o | cb[e];
                cnt++;
            end
        end
    endtask

    task automatic clear_models();
        for (int e = 0; e < 8; e++) begin ma[e] = '0; ca[e] = '0; end
        for (int e = 0; e < 4; e++) begin mb[e] = '0; cb[e] = '0; end
    endtask

    task automatic idle_a();
        bus_a.START = 1'b0; bus_a.MODE = 1'b0; bus_a.I = '0;
        bus_a.TBL_WE = 1'b0; bus_a.TBL_ADDR = '0; bus_a.TBL_MASK = '0; bus_a.TBL_CODE = '0;
    endtask

    task automatic idle_b();
        bus_b.START = 1'b0; bus_b.MODE = 1'b0; bus_b.I = '0;
        bus_b.TBL_WE = 1'b0; bus_b.TBL_ADDR = '0; bus_b.TBL_MASK = '0; bus_b.TBL_CODE = '0;
    endtask

    task automatic wr_a(input int addr, input logic [7:0] mask, input logic [3:0] code);
        @(negedge clk);
        bus_a.TBL_WE = 1'b1; bus_a.TBL_ADDR = 3'(addr);
        bus_a.TBL_MASK = mask; bus_a.TBL_CODE = code;
        ma[addr] = mask; ca[addr] = code;
        @(negedge clk);
        bus_a.TBL_WE = 1'b0;
    endtask

    // One full scan on build A; optional same-cycle table write and optional busy-time interference.
    task automatic scan_a(input logic [7:0] i, input logic mode, input bit interfere,
                          input bit wr, input int waddr, input logic [7:0] wmask, input logic [3:0] wcode);
        logic [3:0] eo;
        int ec, cyc, busy_n;
        bit seen;
        @(negedge clk);
        bus_a.START = 1'b1; bus_a.I = i; bus_a.MODE = mode;
        if (wr) begin
            bus_a.TBL_WE = 1'b1; bus_a.TBL_ADDR = 3'(waddr);
            bus_a.TBL_MASK = wmask; bus_a.TBL_CODE = wcode;
            ma[waddr] = wmask; ca[waddr] = wcode;
        end
        model_a(i, mode, eo, ec);
        @(negedge clk);
        bus_a.START = 1'b0; bus_a.TBL_WE = 1'b0;
        busy_n = bus_a.BUSY ? 1 : 0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            if (interfere && cyc >= 1 && cyc < 8) begin
                bus_a.START = 1'($urandom); bus_a.I = 8'($urandom); bus_a.MODE = 1'($urandom);
                bus_a.TBL_WE = 1'b1; bus_a.TBL_ADDR = 3'd7;
                bus_a.TBL_MASK = 8'($urandom_range(0, 254)); bus_a.TBL_CODE = 4'($urandom);
            end else if (cyc >= 8) begin
                bus_a.START = 1'b0; bus_a.TBL_WE = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (bus_a.DONE) seen = 1;
            else if (bus_a.BUSY) busy_n++;
        end
        chk("a_latency", cyc, 10);
        chk("a_busy_cycles", busy_n, 10);
        chk("a_busy_at_done", bus_a.BUSY, 0);
        chk("a_O", bus_a.O, eo);
        chk("a_MATCH_CNT", bus_a.MATCH_CNT, ec);
        @(negedge clk);
        chk("a_done_pulse", bus_a.DONE, 0);
        chk("a_O_held", bus_a.O, eo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ri;
        logic [1:0] eob;
        int ecb, dones, t [3], cyc, dcount;

        clear_models();
        idle_a();
        idle_b();
        // Reset while START and TBL_WE are asserted.
        rst = 1'b1;
        bus_a.START = 1'b1; bus_a.TBL_WE = 1'b1; bus_a.TBL_ADDR = 3'd3;
        bus_a.TBL_MASK = 8'hFF; bus_a.TBL_CODE = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_O", bus_a.O, 0);
        chk("rst_MATCH_CNT", bus_a.MATCH_CNT, 0);
        chk("rst_DONE", bus_a.DONE, 0);
        chk("rst_BUSY", bus_a.BUSY, 0);
        idle_a();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_BUSY", bus_a.BUSY, 0);
        chk("post_rst_DONE", bus_a.DONE, 0);

        // Empty table: all-zero masks.
        scan_a(8'h00, 1'b0, 0, 0, 0, 8'h0, 4'h0);
        chk("zero_tbl_cnt8", bus_a.MATCH_CNT, 8);
        scan_a(8'h01, 1'b0, 0, 0, 0, 8'h0, 4'h0);
        chk("zero_tbl_cnt0", bus_a.MATCH_CNT, 0);

        for (int e = 0; e < 8; e++) wr_a(e, 8'h00, 4'h2);
        wr_a(0, 8'hF0, 4'h1);
        wr_a(3, 8'h0F, 4'h4);
        wr_a(7, 8'hFF, 4'h8);
        scan_a(8'h30, 1'b0, 0, 0, 0, 8'h0, 4'h0);
        chk("subset_O9", bus_a.O, 4'h9);
        scan_a(8'h30, 1'b1, 0, 0, 0, 8'h0, 4'h0);
        chk("exact_O0", bus_a.O, 4'h0);

        // Busy-time writes/START/I must not disturb the scan or entry 7.
        scan_a(8'h30, 1'b0, 1, 0, 0, 8'h0, 4'h0);
        scan_a(8'hFF, 1'b1, 0, 0, 0, 8'h0, 4'h0);
        chk("entry7_kept", bus_a.O, 4'h8);

        // Reset in the 4th LOOP cycle.
        @(negedge clk);
        bus_a.START = 1'b1; bus_a.I = 8'h30; bus_a.MODE = 1'b0;
        @(negedge clk);
        bus_a.START = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_models();
        chk("midrst_O", bus_a.O, 0);
        chk("midrst_MATCH_CNT", bus_a.MATCH_CNT, 0);
        chk("midrst_DONE", bus_a.DONE, 0);
        chk("midrst_BUSY", bus_a.BUSY, 0);
        dcount = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus_a.DONE) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        scan_a(8'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 8'h0, 4'h0);

        // Randomized scans against the model.
        for (int n = 0; n < 20; n++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++)
                wr_a($urandom_range(0, 7), 8'($urandom), 4'($urandom));
            ri = ($urandom_range(0, 1) == 1) ? ma[$urandom_range(0, 7)] : 8'($urandom);
            scan_a(ri, 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, 7), 8'($urandom), 4'($urandom));
        end
        idle_a();

        // Build B: START held high for three back-to-back scans.
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            bus_b.TBL_WE = 1'b1; bus_b.TBL_ADDR = 2'(e);
            mb[e] = (e == 0) ? 4'hF : 4'($urandom);
            cb[e] = 2'($urandom);
            bus_b.TBL_MASK = mb[e]; bus_b.TBL_CODE = cb[e];
        end
        @(negedge clk);
        bus_b.TBL_WE = 1'b0;
        bus_b.START = 1'b1; bus_b.I = 4'h3; bus_b.MODE = 1'b0;
        model_b(4'h3, 1'b0, eob, ecb);
        dones = 0;
        cyc = 0;
        while (dones < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus_b.DONE) begin
                t[dones] = cyc;
                dones++;
                chk("b_O", bus_b.O, eob);
                chk("b_MATCH_CNT", bus_b.MATCH_CNT, ecb);
                chk("b_cnt_le_depth", (bus_b.MATCH_CNT <= 3'd4), 1);
                if (dones == 3) bus_b.START = 1'b0;
            end
        end
        chk("b_dones", dones, 3);
        if (dones == 3) begin
            chk("b_first_latency", t[0], 7);
            chk("b_spacing_1", t[1] - t[0], 7);
            chk("b_spacing_2", t[2] - t[1], 7);
        end
        @(negedge clk);
        chk("b_done_pulse", bus_b.DONE, 0);
        repeat (10) @(negedge clk);
        chk("b_stopped", bus_b.BUSY, 0);
        idle_b();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
